// File: rtl/mips_muldiv_sequencer_if.sv
// ----------------------------------------------------------------------------
// mips_muldiv_sequencer_if
//   Bundle between the core control unit and the HI/LO multiply/divide
//   sequencer.
//   master (core side)      : drives op_valid, op, rs_data, rt_data, rd_req
//                             and observes op_ready, busy, stall, done, hi, lo
//   slave  (sequencer side) : the mirror image of master
//   op encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI,
//                101 MTLO, 11x reserved
// ----------------------------------------------------------------------------
interface mips_muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             rd_req;
  logic             op_ready;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, rs_data, rt_data, rd_req,
    input  op_ready, busy, stall, done, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data, rd_req,
    output op_ready, busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// mips_muldiv_sequencer
//   Multi-cycle HI/LO multiply/divide unit. It owns HI/LO, runs a WIDTH-step
//   shift-add multiply or restoring divide on operand magnitudes, and then
//   fixes up the signs in a final cycle. It raises stall while busy whenever
//   the core presents a new op or a MFHI/MFLO read.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of mips_muldiv_sequencer_if (op/operands in;
//           op_ready, busy, stall, done, hi, lo out)
// ----------------------------------------------------------------------------
module mips_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_muldiv_sequencer_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_SIGN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;     // MUL: upper product half, DIV: partial remainder
  logic [WIDTH-1:0] r_q;       // MUL: multiplier / lower product, DIV: quotient
  logic [WIDTH-1:0] r_b;       // |multiplicand| or |divisor|
  logic             r_is_div;
  logic             r_neg_res; // operand signs differ on a signed op
  logic             r_neg_a;   // signed dividend was negative
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_arith;
  logic             w_legal;
  logic             w_accept;
  logic             w_signed;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_rs;
  logic [WIDTH-1:0] w_abs_rt;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_div_ok;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    w_is_arith = ~bus.op[2];
    w_legal    = w_is_arith || (bus.op[1] == 1'b0);
    w_accept   = bus.op_valid && (r_state == S_IDLE) && w_legal;
    w_signed   = ~bus.op[0];
    w_last     = (r_cnt == CW'(WIDTH - 1));
    // 0x80000000 negates to itself, which read as unsigned is the true magnitude
    w_abs_rs   = (w_signed && bus.rs_data[WIDTH-1]) ? neg(bus.rs_data) : bus.rs_data;
    w_abs_rt   = (w_signed && bus.rt_data[WIDTH-1]) ? neg(bus.rt_data) : bus.rt_data;

    w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_shift    = {r_acc, r_q[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_b};
    w_div_ok   = ~w_diff[WIDTH];

    w_prod     = {r_acc, r_q};
    w_prod_neg = ~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1};

    if (r_is_div) begin
      // remainder follows the dividend sign; with a zero divisor the magnitude
      // left in r_acc is |rs|, so this restores rs_data exactly
      w_res_hi = r_neg_a ? neg(r_acc) : r_acc;
      w_res_lo = (r_b == '0) ? '1 : (r_neg_res ? neg(r_q) : r_q);
    end else begin
      {w_res_hi, w_res_lo} = r_neg_res ? w_prod_neg : w_prod;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_arith) w_next = bus.op[1] ? S_DIV : S_MUL;
      S_MUL:   if (w_last) w_next = S_SIGN;
      S_DIV:   if (w_last) w_next = S_SIGN;
      S_SIGN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.op_ready = (r_state == S_IDLE);
    bus.busy     = (r_state != S_IDLE);
    bus.stall    = (r_state != S_IDLE) && (bus.op_valid || bus.rd_req);
    bus.done     = r_done;
    bus.hi       = r_hi;
    bus.lo       = r_lo;
  end

  // datapath and HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= (w_accept && !w_is_arith) || (r_state == S_SIGN);
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_arith) begin
            r_is_div  <= bus.op[1];
            r_acc     <= '0;
            r_q       <= w_abs_rs;
            r_b       <= w_abs_rt;
            r_cnt     <= '0;
            r_neg_res <= w_signed && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            r_neg_a   <= w_signed && bus.rs_data[WIDTH-1];
          end else if (w_accept) begin
            if (bus.op[0]) r_lo <= bus.rs_data;
            else           r_hi <= bus.rs_data;
          end
        end
        S_MUL: begin
          // {acc,q} = ({acc + (q[0] ? b : 0), q}) >> 1
          r_acc <= w_mul_sum[WIDTH:1];
          r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_DIV: begin
          r_acc <= w_div_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_div_ok};
          r_cnt <= r_cnt + CW'(1);
        end
        S_SIGN: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
